// File: rtl/gray_decoder_checker.sv
// gray_decoder_checker: Gray-to-binary decoder with single-step integrity check, lock FSM and error counter
//
// Ports:
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   gray_in    in   WIDTH      Gray code from the upstream encoder
//   gray_valid in   1          gray_in sampled on each edge where this is 1
//   clear_err  in   1          synchronous clear of err_count (wins over a new error)
//   bin_out    out  WIDTH      decoded binary value, holds when bin_valid=0
//   bin_valid  out  1          1-cycle pulse per accepted sample, 2 cycles after it was sampled
//   step_err   out  1          1-cycle pulse: the sample on bin_out broke the single-step rule
//   err_count  out  ERR_CNT_W  saturating count of step errors
//   locked     out  1          1 while the FSM is in LOCKED
module gray_decoder_checker #(
   parameter int WIDTH     = 4,
   parameter int LOCK_CNT  = 3,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     gray_in,
   input  logic                 gray_valid,
   input  logic                 clear_err,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 bin_valid,
   output logic                 step_err,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 locked
);
   localparam int GW = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     g1_q, ref_q, bin_q;
   logic                 v1_q, bin_valid_q, step_err_q;
   logic [GW-1:0]        good_q;
   logic [ERR_CNT_W-1:0] err_q;
   logic [WIDTH-1:0]     bin_d, diff_d;
   logic                 one_d, bad_d, err_d;

   // Binary MSB equals Gray MSB; each lower bit folds in the bits above it.
   always_comb begin
      bin_d[WIDTH-1] = g1_q[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) bin_d[i] = bin_d[i+1] ^ g1_q[i];
      diff_d = g1_q ^ ref_q;
      one_d  = $countones(diff_d) == 1;
      bad_d  = $countones(diff_d) > 1;
      // No reference exists yet in IDLE, so the first sample can never be an error.
      err_d  = v1_q && (state_q != IDLE) && bad_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         g1_q        <= '0;
         v1_q        <= 1'b0;
         ref_q       <= '0;
         bin_q       <= '0;
         bin_valid_q <= 1'b0;
         step_err_q  <= 1'b0;
         good_q      <= '0;
         err_q       <= '0;
      end else begin
         v1_q        <= gray_valid;
         bin_valid_q <= v1_q;
         step_err_q  <= err_d;
         if (gray_valid) g1_q <= gray_in;
         if (v1_q) begin
            bin_q <= bin_d;
            ref_q <= g1_q;
         end
         err_q <= clear_err ? '0 : (err_d && !(&err_q)) ? err_q + ERR_CNT_W'(1) : err_q;
         if (v1_q) begin
            case (state_q)
               IDLE: begin
                  good_q  <= '0;
                  state_q <= ACQUIRE;
               end
               ACQUIRE: begin
                  if (bad_d) good_q <= '0;
                  else if (one_d) begin
                     good_q <= good_q + GW'(1);
                     if (good_q == GW'(LOCK_CNT - 1)) state_q <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (bad_d) begin
                     good_q  <= '0;
                     state_q <= ACQUIRE;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bin_out   = bin_q;
   assign bin_valid = bin_valid_q;
   assign step_err  = step_err_q;
   assign err_count = err_q;
   assign locked    = (state_q == LOCKED);
endmodule
